// File: rtl/uart_rx_core.sv
// UART receive path: 16x-oversampled start/data/parity/stop FSM feeding a show-ahead receive FIFO.
// Define UART_RX_SYNC_EN to pass srx_pad_i through a two-flop synchronizer (+2 clk_i latency).
module uart_rx_core #(
  parameter int   FIFO_DEPTH = 16,
  parameter int   COUNT_W    = 5,
  parameter logic SYNC_INIT  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         lcr,
  input  logic               enable,
  input  logic               srx_pad_i,
  input  logic               rf_pop,
  output logic [10:0]        rf_data_out,
  output logic [COUNT_W-1:0] rf_count,
  output logic               rf_push_pulse,
  output logic               rf_error_bit,
  output logic               rf_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_t;

  state_t             state, state_nxt;
  logic               rx_line;
  logic               line_prev;
  logic [3:0]         tick_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         data_q;
  logic               par_err_q;
  logic               any_one_q;
  logic               bit_stb;
  logic               fifo_wr;
  logic               last_bit;
  logic               par_exp;
  logic [10:0]        wr_entry;
  logic [10:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] err_cnt;
  logic               full, empty, wr_ok, pop_ok, ovr_set;
  logic               unused_lcr;

  assign unused_lcr = ^{lcr[7:6], lcr[2]};

`ifdef UART_RX_SYNC_EN
  logic rx_p0, rx_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_p0 <= SYNC_INIT;
      rx_p1 <= SYNC_INIT;
    end else begin
      rx_p0 <= srx_pad_i;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_line = rx_p1;
`else
  assign rx_line = srx_pad_i;
`endif

  // Word length is 5..8, so the last data bit index is {1, lcr[1:0]}
  assign last_bit = (bit_cnt == {1'b1, lcr[1:0]});
  assign par_exp  = lcr[5] ? ~lcr[4] : (lcr[4] ? ^data_q : ~^data_q);
  assign wr_entry = {data_q, ~(any_one_q | rx_line), par_err_q, ~rx_line};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable && line_prev && !rx_line) state_nxt = S_START;
      S_START:  if (enable && tick_cnt == 4'd6) state_nxt = rx_line ? S_IDLE : S_DATA;
      S_DATA:   if (bit_stb && last_bit) state_nxt = lcr[3] ? S_PARITY : S_STOP;
      S_PARITY: if (bit_stb) state_nxt = S_STOP;
      S_STOP:   if (bit_stb) state_nxt = S_PUSH;
      S_PUSH:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bit_stb = 1'b0;
    fifo_wr = 1'b0;
    if (enable && tick_cnt == 4'd15 &&
        (state == S_DATA || state == S_PARITY || state == S_STOP))
      bit_stb = 1'b1;
    if (state == S_STOP && bit_stb)
      fifo_wr = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      line_prev <= SYNC_INIT;
    end else begin
      if (enable) line_prev <= rx_line;
      if (state == S_IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (enable) begin
        tick_cnt <= (state == S_START && tick_cnt == 4'd6) ? 4'd0 : tick_cnt + 4'd1;
        if (state == S_DATA && bit_stb) bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Frame datapath: cleared while idle, captured on each mid-bit strobe
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE) begin
      data_q    <= '0;
      par_err_q <= 1'b0;
      any_one_q <= 1'b0;
    end else if (bit_stb) begin
      any_one_q <= any_one_q | rx_line;
      if (state == S_DATA)   data_q[bit_cnt] <= rx_line;
      if (state == S_PARITY) par_err_q <= (rx_line != par_exp);
    end
  end

  assign full    = (rf_count == COUNT_W'(FIFO_DEPTH));
  assign empty   = (rf_count == '0);
  assign pop_ok  = rf_pop && !empty;
  assign wr_ok   = fifo_wr && (!full || pop_ok);
  assign ovr_set = fifo_wr && full && !rf_pop;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rf_count      <= '0;
      err_cnt       <= '0;
      rf_overrun    <= 1'b0;
      rf_push_pulse <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      rf_count <= rf_count + COUNT_W'(wr_ok) - COUNT_W'(pop_ok);
      err_cnt  <= err_cnt + COUNT_W'(wr_ok && (|wr_entry[2:0]))
                          - COUNT_W'(pop_ok && (|mem[rd_ptr][2:0]));
      if (ovr_set)     rf_overrun <= 1'b1;
      else if (rf_pop) rf_overrun <= 1'b0;
      rf_push_pulse <= wr_ok;
    end
  end

  assign rf_data_out  = empty ? '0 : mem[rd_ptr];
  assign rf_error_bit = (err_cnt != '0);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: table of single frames plus break, glitch, overrun and reset sequences.
module tb_uart_rx_core;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  lcr = 8'h03;
  logic        enable = 1'b1;
  logic        srx_pad_i = 1'b1;
  logic        rf_pop = 1'b0;
  logic [10:0] rf_data_out;
  logic [4:0]  rf_count;
  logic        rf_push_pulse;
  logic        rf_error_bit;
  logic        rf_overrun;

  uart_rx_core dut (
    .clk_i(clk_i), .rst_i(rst_i), .lcr(lcr), .enable(enable), .srx_pad_i(srx_pad_i),
    .rf_pop(rf_pop), .rf_data_out(rf_data_out), .rf_count(rf_count),
    .rf_push_pulse(rf_push_pulse), .rf_error_bit(rf_error_bit), .rf_overrun(rf_overrun)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  lcr;
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [10:0] exp;
    logic        err;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt = 0;
  int cnt_at_pulse = 0;
  logic [10:0] sb[$];

  always @(negedge clk_i) begin
    if (rf_push_pulse) begin
      push_cnt++;
      cnt_at_pulse = int'(rf_count);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    srx_pad_i = v;
    repeat (16) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] d, input logic par, input logic stop);
    int nb;
    lcr = l;
    nb = 5 + int'(l[1:0]);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (l[3]) send_bit(par);
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic pop_check(input string name);
    logic [10:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, head %0h", name, rf_data_out);
    end else begin
      e = sb.pop_front();
      check(name, 32'(rf_data_out), 32'(e));
    end
    rf_pop = 1'b1;
    @(negedge clk_i);
    rf_pop = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    int   p0;

    vecs[0] = '{8'h03, 8'hA5, 1'b0, 1'b1, 11'h528, 1'b0};
    vecs[1] = '{8'h1B, 8'h01, 1'b0, 1'b1, 11'h00A, 1'b1};
    vecs[2] = '{8'h1B, 8'h01, 1'b1, 1'b1, 11'h008, 1'b0};
    vecs[3] = '{8'h0B, 8'h01, 1'b0, 1'b1, 11'h008, 1'b0};
    vecs[4] = '{8'h00, 8'h1F, 1'b0, 1'b1, 11'h0F8, 1'b0};
    vecs[5] = '{8'h01, 8'h2A, 1'b0, 1'b1, 11'h150, 1'b0};
    vecs[6] = '{8'h02, 8'h7F, 1'b0, 1'b0, 11'h3F9, 1'b1};
    vecs[7] = '{8'h2B, 8'h3C, 1'b1, 1'b1, 11'h1E0, 1'b0};
    vecs[8] = '{8'h3B, 8'h80, 1'b1, 1'b1, 11'h402, 1'b1};
    vecs[9] = '{8'h00, 8'hFF, 1'b0, 1'b1, 11'h0F8, 1'b0};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("reset_count", 32'(rf_count), 0);
    check("reset_data", 32'(rf_data_out), 0);
    check("reset_push", 32'(rf_push_pulse), 0);
    check("reset_overrun", 32'(rf_overrun), 0);
    check("reset_error", 32'(rf_error_bit), 0);

    foreach (vecs[k]) begin
      p0 = push_cnt;
      sb.push_back(vecs[k].exp);
      send_frame(vecs[k].lcr, vecs[k].data, vecs[k].par, vecs[k].stop);
      check($sformatf("vec%0d_pushes", k), push_cnt - p0, 1);
      check($sformatf("vec%0d_count_at_pulse", k), cnt_at_pulse, 1);
      check($sformatf("vec%0d_count", k), 32'(rf_count), 1);
      check($sformatf("vec%0d_error_bit", k), 32'(rf_error_bit), 32'(vecs[k].err));
      pop_check($sformatf("vec%0d_head", k));
      check($sformatf("vec%0d_count_after_pop", k), 32'(rf_count), 0);
    end

    // Break: line low for 20 bit times yields exactly one break+framing entry
    lcr = 8'h03;
    p0 = push_cnt;
    sb.push_back(11'h005);
    srx_pad_i = 1'b0;
    repeat (320) @(negedge clk_i);
    check("break_pushes_while_low", push_cnt - p0, 1);
    srx_pad_i = 1'b1;
    repeat (64) @(negedge clk_i);
    check("break_pushes", push_cnt - p0, 1);
    check("break_count", 32'(rf_count), 1);
    check("break_error_bit", 32'(rf_error_bit), 1);
    pop_check("break_head");

    // Short low glitch is rejected; a normal frame afterwards still decodes
    p0 = push_cnt;
    srx_pad_i = 1'b0;
    repeat (4) @(negedge clk_i);
    srx_pad_i = 1'b1;
    repeat (48) @(negedge clk_i);
    check("glitch_pushes", push_cnt - p0, 0);
    check("glitch_count", 32'(rf_count), 0);
    sb.push_back(11'h1E0);
    send_frame(8'h03, 8'h3C, 1'b0, 1'b1);
    check("post_glitch_count", 32'(rf_count), 1);
    pop_check("post_glitch_head");

    // Error flag covers every queued entry, not only the head
    sb.push_back(11'h00A);
    send_frame(8'h1B, 8'h01, 1'b0, 1'b1);
    sb.push_back(11'h528);
    send_frame(8'h03, 8'hA5, 1'b0, 1'b1);
    check("err2_count", 32'(rf_count), 2);
    check("err2_error_bit", 32'(rf_error_bit), 1);
    pop_check("err2_head0");
    check("err2_error_bit_after_pop", 32'(rf_error_bit), 0);
    pop_check("err2_head1");

    // Overrun: 17 frames into a 16-deep FIFO, the last one is dropped
    p0 = push_cnt;
    for (int i = 0; i < 17; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      if (i < 16) sb.push_back({d, 3'b000});
      send_frame(8'h03, d, 1'b0, 1'b1);
    end
    check("ovr_pushes", push_cnt - p0, 16);
    check("ovr_count", 32'(rf_count), 16);
    check("ovr_flag", 32'(rf_overrun), 1);
    check("ovr_error_bit", 32'(rf_error_bit), 0);
    pop_check("ovr_head_first");
    check("ovr_count_after_pop", 32'(rf_count), 15);
    check("ovr_flag_after_pop", 32'(rf_overrun), 0);
    check("ovr_head_second", 32'(rf_data_out), 32'h088);
    for (int i = 0; i < 15; i++) pop_check($sformatf("ovr_drain%0d", i));
    check("ovr_drained_count", 32'(rf_count), 0);
    check("ovr_drained_data", 32'(rf_data_out), 0);

    // Reset mid-frame: FIFO cleared and the partial frame never lands
    sb.push_back(11'h0F8);
    send_frame(8'h00, 8'h1F, 1'b0, 1'b1);
    check("rst_pre_count", 32'(rf_count), 1);
    check("rst_pre_head", 32'(rf_data_out), 32'h0F8);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    sb.delete();
    p0 = push_cnt;
    repeat (96) @(negedge clk_i);
    check("rst_mid_count", 32'(rf_count), 0);
    check("rst_mid_pushes", push_cnt - p0, 0);
    check("rst_mid_data", 32'(rf_data_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
